// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - PC/IF_ID/ID_EX stall, bubble and flush sequencer
// Optional performance counters enabled by defining PERF_CNT_EN.
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 1023,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ID_EX_MemRead_i,
    input  logic [4:0]       ID_EX_Rd_i,
    input  logic [4:0]       IF_ID_Rs_i,
    input  logic [4:0]       IF_ID_Rt_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             PC_Write_o,
    output logic             IF_ID_Write_o,
    output logic             IF_Flush_o,
    output logic             ID_EX_Bubble_o,
    output logic             stall_o,
    output logic             mem_err_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_err_q;
    logic              load_use;
    logic              stall_raw;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Request and ack in the same cycle is a hit: no wait state.
                    if (mem_req_i && !mem_ack_i) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack_i) begin
                        state <= IDLE;
                    end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state     <= MEM_ERR;
                        mem_err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                MEM_ERR: state <= MEM_ERR;
                default: state <= IDLE;
            endcase
        end
    end

    assign stall_raw = ((state == IDLE) && mem_req_i && !mem_ack_i) ||
                       ((state == MEM_WAIT) && !mem_ack_i) ||
                       (state == MEM_ERR);

    assign load_use = ID_EX_MemRead_i && (ID_EX_Rd_i != 5'd0) &&
                      ((ID_EX_Rd_i == IF_ID_Rs_i) || (ID_EX_Rd_i == IF_ID_Rt_i));

    // Memory stall outranks the branch flush: IF_ID would otherwise let the
    // flush win and lose the instruction held during the freeze.
    always_comb begin
        stall_o        = 1'b0;
        PC_Write_o     = 1'b0;
        IF_ID_Write_o  = 1'b0;
        IF_Flush_o     = 1'b0;
        ID_EX_Bubble_o = 1'b0;
        if (!rst_i) begin
            stall_o = stall_raw;
            if (stall_raw) begin
                PC_Write_o    = 1'b0;
            end else if (load_use) begin
                ID_EX_Bubble_o = 1'b1;
            end else if (branch_taken_i) begin
                IF_Flush_o    = 1'b1;
                PC_Write_o    = 1'b1;
                IF_ID_Write_o = 1'b1;
            end else begin
                PC_Write_o    = 1'b1;
                IF_ID_Write_o = 1'b1;
            end
        end
    end

    assign mem_err_o = mem_err_q;
    assign state_o   = state;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_o && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (IF_Flush_o && !(&flush_cnt)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    localparam int CNT_W = 32;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             ID_EX_MemRead_i;
    logic [4:0]       ID_EX_Rd_i;
    logic [4:0]       IF_ID_Rs_i;
    logic [4:0]       IF_ID_Rt_i;
    logic             branch_taken_i;
    logic             mem_req_i;
    logic             mem_ack_i;
    logic             PC_Write_o;
    logic             IF_ID_Write_o;
    logic             IF_Flush_o;
    logic             ID_EX_Bubble_o;
    logic             stall_o;
    logic             mem_err_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    int checks = 0;
    int errors = 0;

    hazard_stall_ctrl #(.MEM_TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ID_EX_MemRead_i(ID_EX_MemRead_i), .ID_EX_Rd_i(ID_EX_Rd_i),
        .IF_ID_Rs_i(IF_ID_Rs_i), .IF_ID_Rt_i(IF_ID_Rt_i),
        .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
        .PC_Write_o(PC_Write_o), .IF_ID_Write_o(IF_ID_Write_o), .IF_Flush_o(IF_Flush_o),
        .ID_EX_Bubble_o(ID_EX_Bubble_o), .stall_o(stall_o), .mem_err_o(mem_err_o),
        .state_o(state_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic rst, input logic req, input logic ack,
                         input logic br, input logic mr, input logic [4:0] rd,
                         input logic [4:0] rs, input logic [4:0] rt);
        @(negedge clk_i);
        rst_i = rst; mem_req_i = req; mem_ack_i = ack; branch_taken_i = br;
        ID_EX_MemRead_i = mr; ID_EX_Rd_i = rd; IF_ID_Rs_i = rs; IF_ID_Rt_i = rt;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (state_o !== 2'd1) begin
            errors++; $display("FAIL reset_pre_wait: state_o=%0d expected 1", state_o);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if ({PC_Write_o, IF_ID_Write_o, IF_Flush_o, ID_EX_Bubble_o, stall_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_controls: pc=%b ifid=%b flush=%b bub=%b stall=%b expected all 0",
                     PC_Write_o, IF_ID_Write_o, IF_Flush_o, ID_EX_Bubble_o, stall_o);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (state_o !== 2'd0 || mem_err_o !== 1'b0 || stall_cnt_o !== '0 || flush_cnt_o !== '0) begin
            errors++;
            $display("FAIL reset_state: state=%0d err=%b scnt=%0d fcnt=%0d expected 0 0 0 0",
                     state_o, mem_err_o, stall_cnt_o, flush_cnt_o);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic test_load_use();
        logic [3:0] exp [0:4];
        logic [4:0] rd  [0:4];
        logic [4:0] rs  [0:4];
        logic [4:0] rt  [0:4];
        logic       mr  [0:4];
        logic       br  [0:4];
        // {PC_Write, IF_ID_Write, IF_Flush, Bubble}
        exp[0] = 4'b0001; mr[0] = 1; rd[0] = 5;  rs[0] = 5;  rt[0] = 3;  br[0] = 1;
        exp[1] = 4'b1110; mr[1] = 1; rd[1] = 0;  rs[1] = 0;  rt[1] = 0;  br[1] = 1;
        exp[2] = 4'b0001; mr[2] = 1; rd[2] = 7;  rs[2] = 2;  rt[2] = 7;  br[2] = 0;
        exp[3] = 4'b1100; mr[3] = 1; rd[3] = 9;  rs[3] = 8;  rt[3] = 10; br[3] = 0;
        exp[4] = 4'b1100; mr[4] = 0; rd[4] = 12; rs[4] = 12; rt[4] = 12; br[4] = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, br[i], mr[i], rd[i], rs[i], rt[i]);
            checks++;
            if ({PC_Write_o, IF_ID_Write_o, IF_Flush_o, ID_EX_Bubble_o} !== exp[i]) begin
                errors++;
                $display("FAIL load_use[%0d]: pc/ifid/flush/bub=%b expected %b", i,
                         {PC_Write_o, IF_ID_Write_o, IF_Flush_o, ID_EX_Bubble_o}, exp[i]);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic test_miss();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b1, (c == 4), 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
            checks++;
            if (stall_o !== (c != 4) || state_o !== ((c == 0) ? 2'd0 : 2'd1) ||
                PC_Write_o !== (c == 4)) begin
                errors++;
                $display("FAIL miss_cycle[%0d]: stall=%b state=%0d pc=%b expected %b %0d %b",
                         c, stall_o, state_o, PC_Write_o, (c != 4), (c == 0) ? 0 : 1, (c == 4));
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (state_o !== 2'd0) begin
            errors++; $display("FAIL miss_return: state_o=%0d expected 0", state_o);
        end
`ifdef PERF_CNT_EN
        checks++;
        if (stall_cnt_o !== 32'd4) begin
            errors++; $display("FAIL miss_stall_cnt: stall_cnt_o=%0d expected 4", stall_cnt_o);
        end
`endif
    endtask

    task automatic test_stall_branch();
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (IF_Flush_o !== 1'b0 || stall_o !== 1'b1 || PC_Write_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_branch_idle: flush=%b stall=%b pc=%b expected 0 1 0",
                     IF_Flush_o, stall_o, PC_Write_o);
        end
        // Load-use during a stall must not bubble: the freeze has priority.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 5'd4, 5'd0);
        checks++;
        if (IF_Flush_o !== 1'b0 || ID_EX_Bubble_o !== 1'b0 || stall_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_over_loaduse: flush=%b bub=%b stall=%b expected 0 0 1",
                     IF_Flush_o, ID_EX_Bubble_o, stall_o);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (IF_Flush_o !== 1'b1 || stall_o !== 1'b0 || PC_Write_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_branch_ack: flush=%b stall=%b pc=%b expected 1 0 1",
                     IF_Flush_o, stall_o, PC_Write_o);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
`ifdef PERF_CNT_EN
        checks++;
        if (flush_cnt_o !== 32'd1 || stall_cnt_o !== 32'd2) begin
            errors++;
            $display("FAIL stall_branch_cnt: flush_cnt=%0d stall_cnt=%0d expected 1 2",
                     flush_cnt_o, stall_cnt_o);
        end
`endif
    endtask

    task automatic test_hit();
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (stall_o !== 1'b0 || PC_Write_o !== 1'b1) begin
            errors++; $display("FAIL hit_stall: stall=%b pc=%b expected 0 1", stall_o, PC_Write_o);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (state_o !== 2'd0 || stall_o !== 1'b0) begin
            errors++; $display("FAIL hit_state: state=%0d stall=%b expected 0 0", state_o, stall_o);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (state_o !== 2'd0) begin
            errors++; $display("FAIL stray_ack_state: state=%0d expected 0", state_o);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
            checks++;
            if (state_o !== 2'd1 || mem_err_o !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait[%0d]: state=%0d err=%b expected 1 0", k, state_o, mem_err_o);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (state_o !== 2'd2 || mem_err_o !== 1'b1 || stall_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err: state=%0d err=%b stall=%b expected 2 1 1", state_o, mem_err_o, stall_o);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (state_o !== 2'd2 || stall_o !== 1'b1 || PC_Write_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: state=%0d stall=%b pc=%b expected 2 1 0", state_o, stall_o, PC_Write_o);
        end
        do_reset();
        checks++;
        if (state_o !== 2'd0 || mem_err_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: state=%0d err=%b stall=%b expected 0 0 0", state_o, mem_err_o, stall_o);
        end
    endtask

    initial begin
        rst_i = 1'b1; mem_req_i = 1'b0; mem_ack_i = 1'b0; branch_taken_i = 1'b0;
        ID_EX_MemRead_i = 1'b0; ID_EX_Rd_i = '0; IF_ID_Rs_i = '0; IF_ID_Rt_i = '0;
        test_reset();
        test_load_use();
        test_miss();
        test_stall_branch();
        test_hit();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
